dphy_lane_deser: RTL and testbench

DPHY_LANE_DESER -- requirements
Module: dphy_lane_deser

---
 rtl/dphy_lane_deser.sv | 181 ++++++++++++++++++
 tb/tb_dphy_lane_deser.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_lane_deser.sv
// dphy_lane_deser: D-PHY HS receive deserializer; hunts a sync byte per lane, aligns lanes, emits bytes.
// Optional feature macro: DPHY_LANE_DESER_SYNC_TOL_EN accepts sync windows within Hamming distance 1.
module dphy_lane_deser #(
    parameter int         LANES     = 2,
    parameter int         DIN_W     = 2,
    parameter logic [7:0] SYNC_WORD = 8'hB8,
    parameter int         TIMEOUT   = 64
) (
    input  logic                   dphy_clk,
    input  logic                   reset,
    input  logic                   hs_en,
    input  logic [LANES*DIN_W-1:0] din,
    output logic [LANES*8-1:0]     dout,
    output logic                   dout_valid,
    output logic                   locked,
    output logic                   sync_err,
    output logic                   hunt_timeout,
    output logic [1:0]             state_dbg
);
    // dout/dout_valid is a valid-only strobe with no ready: the consumer takes dout in the
    // cycle dout_valid is high; dout holds its value between strobes.

    localparam int               N           = 8 / DIN_W;
    localparam int               PH_W        = (N > 1) ? $clog2(N) : 1;
    localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(N - 1);
    localparam logic [PH_W-1:0]  PH_START    = (N > 1) ? PH_W'(1) : PH_W'(0);
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        FAIL   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       sr_q     [LANES];
    logic [2:0]        off_q    [LANES];
    logic [2:0]        cand_off [LANES];
    logic [7:0]        hunt_cnt_q, hunt_cnt_d, hunt_cnt_inc;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [LANES-1:0]  lane_exact, lane_loose;
    logic              all_match;
    logic              byte_done, lock_hit, timeout_hit;
    logic [LANES*8-1:0] dout_win;

    // Window whose last (newest) bit sits j positions below the top of the shift register.
    function automatic logic [7:0] window(input logic [15:0] sr, input logic [2:0] j);
        return 8'(sr >> (4'd8 - {1'b0, j}));
    endfunction

`ifdef DPHY_LANE_DESER_SYNC_TOL_EN
    function automatic logic near_sync(input logic [7:0] w);
        logic [7:0] d;
        d = w ^ SYNC_WORD;
        return (d & (d - 8'd1)) == 8'd0;
    endfunction
`endif

    // Later j wins, so the earliest-completed window is kept; exact hits pre-empt loose ones.
    always_comb begin
        lane_exact = '0;
        lane_loose = '0;
        for (int l = 0; l < LANES; l++) begin
            cand_off[l] = 3'd0;
            for (int j = 0; j < DIN_W; j++) begin
                if (window(sr_q[l], 3'(j)) == SYNC_WORD) begin
                    lane_exact[l] = 1'b1;
                    cand_off[l]   = 3'(j);
                end
            end
`ifdef DPHY_LANE_DESER_SYNC_TOL_EN
            if (!lane_exact[l]) begin
                for (int j = 0; j < DIN_W; j++) begin
                    if (near_sync(window(sr_q[l], 3'(j)))) begin
                        lane_loose[l] = 1'b1;
                        cand_off[l]   = 3'(j);
                    end
                end
            end
`endif
        end
    end

    assign all_match    = &(lane_exact | lane_loose);
    assign hunt_cnt_inc = (hunt_cnt_q == 8'hFF) ? 8'hFF : hunt_cnt_q + 8'd1;

    always_comb begin
        dout_win = '0;
        for (int l = 0; l < LANES; l++) begin
            dout_win[l*8 +: 8] = window(sr_q[l], off_q[l]);
        end
    end

    always_comb begin
        state_d     = state_q;
        hunt_cnt_d  = hunt_cnt_q;
        phase_d     = phase_q;
        byte_done   = 1'b0;
        lock_hit    = 1'b0;
        timeout_hit = 1'b0;
        if (!hs_en) begin
            state_d    = IDLE;
            hunt_cnt_d = '0;
            phase_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = HUNT;
                    hunt_cnt_d = '0;
                end
                HUNT: begin
                    if (all_match) begin
                        state_d  = LOCKED;
                        phase_d  = PH_START;
                        lock_hit = 1'b1;
                    end else begin
                        hunt_cnt_d = hunt_cnt_inc;
                        if (hunt_cnt_inc >= TIMEOUT_CNT) begin
                            state_d     = FAIL;
                            timeout_hit = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Phase 0 means a whole byte landed at the stored offsets on the last edge.
                    byte_done = (phase_q == '0);
                    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                end
                FAIL: state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge dphy_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hunt_cnt_q   <= '0;
            phase_q      <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            hunt_timeout <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                sr_q[l]  <= '0;
                off_q[l] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hunt_cnt_q   <= hunt_cnt_d;
            phase_q      <= phase_d;
            dout_valid   <= byte_done;
            hunt_timeout <= timeout_hit;
            if (byte_done) begin
                dout <= dout_win;
            end
            for (int l = 0; l < LANES; l++) begin
                sr_q[l] <= hs_en ? {din[l*DIN_W +: DIN_W], sr_q[l][15:DIN_W]} : 16'd0;
                if (lock_hit) begin
                    off_q[l] <= cand_off[l];
                end
            end
        end
    end

`ifdef DPHY_LANE_DESER_SYNC_TOL_EN
    always_ff @(posedge dphy_clk) begin
        if (reset) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= lock_hit & (|lane_loose);
        end
    end
`else
    assign sync_err = 1'b0;
`endif

    assign locked    = (state_q == LOCKED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dphy_lane_deser.sv
// tb_dphy_lane_deser: directed, table-driven bench for dphy_lane_deser over three parameter sets.
`timescale 1ns/1ps
module tb_dphy_lane_deser;
    localparam logic [7:0] SYNC      = 8'hB8;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    // clock / reset
    logic dphy_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 dphy_clk = ~dphy_clk;

    // A: 2 lanes x 2 bits
    logic        hs_a = 1'b0;
    logic [3:0]  din_a = '0;
    logic [15:0] dout_a;
    logic        valid_a, locked_a, serr_a, hto_a;
    logic [1:0]  st_a;
    // B: 2 lanes x 4 bits
    logic        hs_b = 1'b0;
    logic [7:0]  din_b = '0;
    logic [15:0] dout_b;
    logic        valid_b, locked_b, serr_b, hto_b;
    logic [1:0]  st_b;
    // C: 1 lane x 2 bits, TIMEOUT 10
    logic        hs_c = 1'b0;
    logic [1:0]  din_c = '0;
    logic [7:0]  dout_c;
    logic        valid_c, locked_c, serr_c, hto_c;
    logic [1:0]  st_c;

    dphy_lane_deser #(.LANES(2), .DIN_W(2), .SYNC_WORD(SYNC), .TIMEOUT(64)) u_a (
        .dphy_clk(dphy_clk), .reset(reset), .hs_en(hs_a), .din(din_a), .dout(dout_a),
        .dout_valid(valid_a), .locked(locked_a), .sync_err(serr_a), .hunt_timeout(hto_a),
        .state_dbg(st_a));
    dphy_lane_deser #(.LANES(2), .DIN_W(4), .SYNC_WORD(SYNC), .TIMEOUT(64)) u_b (
        .dphy_clk(dphy_clk), .reset(reset), .hs_en(hs_b), .din(din_b), .dout(dout_b),
        .dout_valid(valid_b), .locked(locked_b), .sync_err(serr_b), .hunt_timeout(hto_b),
        .state_dbg(st_b));
    dphy_lane_deser #(.LANES(1), .DIN_W(2), .SYNC_WORD(SYNC), .TIMEOUT(10)) u_c (
        .dphy_clk(dphy_clk), .reset(reset), .hs_en(hs_c), .din(din_c), .dout(dout_c),
        .dout_valid(valid_c), .locked(locked_c), .sync_err(serr_c), .hunt_timeout(hto_c),
        .state_dbg(st_c));

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [6];

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    int          active   = 0;
    bit          q0 [$];
    bit          q1 [$];
    logic [15:0] obs_a [$];
    logic [15:0] obs_b [$];
    logic [7:0]  obs_c [$];
    int          vedge_a [$];
    int          vedge_b [$];
    logic [15:0] exp_q [$];
    logic        lk_at [64];
    logic        se_at [64];
    logic        to_at [64];
    logic [1:0]  st_at [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic push_zeros(input int lane, input int n);
        for (int i = 0; i < n; i++) begin
            if (lane == 0) q0.push_back(1'b0); else q1.push_back(1'b0);
        end
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (lane == 0) q0.push_back(b[i]); else q1.push_back(b[i]);
        end
    endtask

    function automatic bit pop_bit(input int lane);
        if (lane == 0) return (q0.size() > 0) ? q0.pop_front() : 1'b0;
        return (q1.size() > 0) ? q1.pop_front() : 1'b0;
    endfunction

    task automatic drive();
        din_a = '0;
        din_b = '0;
        din_c = '0;
        case (active)
            0: for (int b = 0; b < 2; b++) begin
                din_a[b]   = pop_bit(0);
                din_a[2+b] = pop_bit(1);
            end
            1: for (int b = 0; b < 4; b++) begin
                din_b[b]   = pop_bit(0);
                din_b[4+b] = pop_bit(1);
            end
            default: for (int b = 0; b < 2; b++) din_c[b] = pop_bit(0);
        endcase
    endtask

    task automatic tick();
        @(posedge dphy_clk);
        #1;
        edge_n++;
        if (valid_a) begin obs_a.push_back(dout_a); vedge_a.push_back(edge_n); end
        if (valid_b) begin obs_b.push_back(dout_b); vedge_b.push_back(edge_n); end
        if (valid_c) obs_c.push_back(dout_c);
        if (edge_n < 64) begin
            case (active)
                0: begin lk_at[edge_n] = locked_a; se_at[edge_n] = serr_a; to_at[edge_n] = hto_a; st_at[edge_n] = st_a; end
                1: begin lk_at[edge_n] = locked_b; se_at[edge_n] = serr_b; to_at[edge_n] = hto_b; st_at[edge_n] = st_b; end
                default: begin lk_at[edge_n] = locked_c; se_at[edge_n] = serr_c; to_at[edge_n] = hto_c; st_at[edge_n] = st_c; end
            endcase
        end
        drive();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input int which);
        active = which;
        edge_n = 0;
        obs_a.delete(); obs_b.delete(); obs_c.delete();
        vedge_a.delete(); vedge_b.delete();
        for (int i = 0; i < 64; i++) begin
            lk_at[i] = 1'b0; se_at[i] = 1'b0; to_at[i] = 1'b0; st_at[i] = 2'd0;
        end
        drive();
    endtask

    task automatic clear_bits();
        q0.delete();
        q1.delete();
    endtask

    // Both lanes: 'lead' zeros, sync bytes, then payload added by the caller.
    task automatic lead_sync(input int lead, input logic [7:0] s0, input logic [7:0] s1);
        clear_bits();
        push_zeros(0, lead); push_zeros(1, lead);
        push_byte(0, s0);    push_byte(1, s1);
    endtask

    // scoreboard: observed bytes of the active 2-lane DUT against exp_q
    task automatic score(input string name, input int first_edge, input int step);
        int n_obs;
        n_obs = (active == 1) ? obs_b.size() : obs_a.size();
        check({name, " valid count"}, 32'(n_obs), 32'(exp_q.size()));
        for (int i = 0; i < n_obs && exp_q.size() > 0; i++) begin
            logic [15:0] exp_w;
            logic [15:0] got_w;
            int          got_e;
            exp_w = exp_q.pop_front();
            if (active == 1) begin got_w = obs_b.pop_front(); got_e = vedge_b.pop_front(); end
            else begin got_w = obs_a.pop_front(); got_e = vedge_a.pop_front(); end
            check({name, " dout"}, 32'(got_w), 32'(exp_w));
            check({name, " valid edge"}, 32'(got_e), 32'(first_edge + i * step));
        end
        exp_q.delete();
    endtask

    initial begin
        int early;
        vecs[0] = '{8'h5A, 8'hC3, 16'hC35A};
        vecs[1] = '{8'hA5, 8'hA5, 16'hA5A5};
        vecs[2] = '{8'h00, 8'hFF, 16'hFF00};
        vecs[3] = '{8'hFF, 8'h00, 16'h00FF};
        vecs[4] = '{8'hB8, 8'hB8, 16'hB8B8};
        vecs[5] = '{8'h01, 8'h80, 16'h8001};

        // reset state
        start(0);
        ticks(2);
        check("rst dout", 32'(dout_a), 32'h0);
        check("rst valid", 32'(valid_a), 32'h0);
        check("rst locked", 32'(locked_a), 32'h0);
        check("rst sync_err", 32'(serr_a), 32'h0);
        check("rst hunt_timeout", 32'(hto_a), 32'h0);
        check("rst state a", 32'(st_a), 32'(ST_IDLE));
        check("rst state c", 32'(st_c), 32'(ST_IDLE));
        reset = 1'b0;

        // A: sync at offset 1, then the table; E0 = edge 8, bytes at 13,17,...
        lead_sync(7, SYNC, SYNC);
        foreach (vecs[i]) begin
            push_byte(0, vecs[i].b0);
            push_byte(1, vecs[i].b1);
            exp_q.push_back(vecs[i].exp);
        end
        hs_a = 1'b1;
        start(0);
        ticks(33);
        check("a locked before E0+1", 32'(lk_at[8]), 32'h0);
        check("a locked at E0+1", 32'(lk_at[9]), 32'h1);
        check("a state locked", 32'(st_at[9]), 32'(ST_LOCKED));
        score("a table", 13, 4);

        hs_a = 1'b0;
        ticks(2);
        check("a hs drop locked", 32'(locked_a), 32'h0);
        check("a hs drop dout hold", 32'(dout_a), 32'h8001);

        // A: 0xA5 stream, hs_en dropped mid third byte
        lead_sync(7, SYNC, SYNC);
        for (int i = 0; i < 3; i++) begin push_byte(0, 8'hA5); push_byte(1, 8'hA5); end
        exp_q.push_back(16'hA5A5); exp_q.push_back(16'hA5A5);
        hs_a = 1'b1;
        start(0);
        ticks(18);
        hs_a = 1'b0;
        ticks(3);
        check("a midbyte locked", 32'(lk_at[19]), 32'h0);
        check("a midbyte state", 32'(st_at[19]), 32'(ST_IDLE));
        check("a midbyte dout hold", 32'(dout_a), 32'hA5A5);
        score("a midbyte", 13, 4);

        // A: hs_en falls in the cycle a byte completes
        lead_sync(7, SYNC, SYNC);
        push_byte(0, 8'h3C); push_byte(1, 8'h3C);
        push_byte(0, 8'h66); push_byte(1, 8'h66);
        exp_q.push_back(16'h3C3C);
        hs_a = 1'b1;
        start(0);
        ticks(16);
        hs_a = 1'b0;
        ticks(2);
        check("a coincident dout hold", 32'(dout_a), 32'h3C3C);
        score("a coincident", 13, 4);

        // A: reset pulse while locked, mid-byte
        lead_sync(7, SYNC, SYNC);
        push_byte(0, 8'h12); push_byte(1, 8'h34);
        exp_q.push_back(16'h3412);
        hs_a = 1'b1;
        start(0);
        ticks(14);
        score("a pre-reset", 13, 4);
        reset = 1'b1;
        tick();
        check("a reset dout", 32'(dout_a), 32'h0);
        check("a reset valid", 32'(valid_a), 32'h0);
        check("a reset locked", 32'(locked_a), 32'h0);
        check("a reset state", 32'(st_a), 32'(ST_IDLE));
        reset = 1'b0;
        lead_sync(21, SYNC, SYNC);
        push_byte(0, 8'h77); push_byte(1, 8'h99);
        exp_q.push_back(16'h9977);
        start(0);
        ticks(20);
        early = 0;
        for (int e = 1; e <= 15; e++) if (lk_at[e]) early++;
        check("a relock needs sync", 32'(early), 32'h0);
        check("a relock locked", 32'(lk_at[16]), 32'h1);
        score("a relock", 20, 4);
        hs_a = 1'b0;
        ticks(2);

        // B: lane1 one bit behind lane0, offsets 3/2
        clear_bits();
        push_zeros(0, 5); push_zeros(1, 6);
        push_byte(0, SYNC); push_byte(1, SYNC);
        push_byte(0, 8'h11); push_byte(1, 8'h22);
        push_byte(0, 8'h33); push_byte(1, 8'h44);
        exp_q.push_back(16'h2211); exp_q.push_back(16'h4433);
        hs_b = 1'b1;
        start(1);
        ticks(9);
        check("b locked before E0+1", 32'(lk_at[4]), 32'h0);
        check("b locked at E0+1", 32'(lk_at[5]), 32'h1);
        score("b skew", 7, 2);
        hs_b = 1'b0;
        ticks(2);

        // C: hunt timeout with constant zeros
        clear_bits();
        hs_c = 1'b1;
        start(2);
        ticks(12);
        early = 0;
        for (int e = 1; e <= 10; e++) if (to_at[e]) early++;
        check("c timeout early", 32'(early), 32'h0);
        check("c timeout pulse", 32'(to_at[11]), 32'h1);
        check("c timeout one cycle", 32'(to_at[12]), 32'h0);
        check("c fail state", 32'(st_at[12]), 32'(ST_FAIL));
        push_zeros(0, 1); push_byte(0, SYNC); push_byte(0, 8'h5A);
        ticks(12);
        early = 0;
        for (int e = 1; e <= 24; e++) if (lk_at[e]) early++;
        check("c no lock in fail", 32'(early), 32'h0);
        check("c no valid in fail", 32'(obs_c.size()), 32'h0);
        clear_bits();
        hs_c = 1'b0;
        tick();
        check("c fail to idle", 32'(st_c), 32'(ST_IDLE));
        clear_bits();
        push_zeros(0, 7); push_byte(0, SYNC); push_byte(0, 8'h5A);
        hs_c = 1'b1;
        start(2);
        ticks(13);
        check("c relock", 32'(lk_at[9]), 32'h1);
        check("c valid count", 32'(obs_c.size()), 32'h1);
        if (obs_c.size() > 0) check("c dout", 32'(obs_c[0]), 32'h5A);
        hs_c = 1'b0;
        ticks(2);

        // A: lane0 sync byte one bit off (0xB9)
        lead_sync(7, 8'hB9, SYNC);
        push_byte(0, 8'h5A); push_byte(1, 8'hC3);
`ifdef DPHY_LANE_DESER_SYNC_TOL_EN
        exp_q.push_back(16'hC35A);
`endif
        hs_a = 1'b1;
        start(0);
        ticks(13);
        check("tol sync_err before lock", 32'(se_at[8]), 32'h0);
`ifdef DPHY_LANE_DESER_SYNC_TOL_EN
        check("tol locked", 32'(lk_at[9]), 32'h1);
        check("tol sync_err pulse", 32'(se_at[9]), 32'h1);
        check("tol sync_err one cycle", 32'(se_at[10]), 32'h0);
`else
        check("exact no lock", 32'(lk_at[9]), 32'h0);
        check("exact no lock late", 32'(lk_at[13]), 32'h0);
        check("exact sync_err zero", 32'(se_at[9]), 32'h0);
`endif
        score("tol data", 13, 4);
        hs_a = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
